// File: rtl/alu_dm_ext.sv
`default_nettype none
// ============================================================================
//  Module   : alu_dm_ext
//  Purpose  : Execute/memory slice of the single-cycle MIPS core.
//             It holds the immediate/jump-target extender, a 32-bit ALU with
//             a selectable second operand, and a word-addressed data memory.
//             The memory has a synchronous write and a combinational read.
//  Options  : DM_DISPLAY_EN - when defined, prints a trace line for each
//             accepted memory write.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_dm_ext #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active low
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [2:0]  extendOp,
  input  logic [2:0]  ALUop,
  input  logic        ALUin2op,
  input  logic        DMop,
  output logic [31:0] extendOut,
  output logic [31:0] out,
  output logic [31:0] DMRD,
  output logic        zero
);

  localparam int AW = $clog2(DEPTH);

  // Extender modes
  localparam logic [2:0] c_EXT_ZERO = 3'd0;
  localparam logic [2:0] c_EXT_SIGN = 3'd1;
  localparam logic [2:0] c_EXT_LUI  = 3'd2;
  localparam logic [2:0] c_EXT_BR   = 3'd3;
  localparam logic [2:0] c_EXT_JMP  = 3'd4;

  // ALU functions
  localparam logic [2:0] c_ALU_ADD  = 3'd0;
  localparam logic [2:0] c_ALU_SUB  = 3'd1;
  localparam logic [2:0] c_ALU_OR   = 3'd2;
  localparam logic [2:0] c_ALU_AND  = 3'd3;
  localparam logic [2:0] c_ALU_EQ   = 3'd4;
  localparam logic [2:0] c_ALU_SLT  = 3'd5;
  localparam logic [2:0] c_ALU_SLTU = 3'd6;
  localparam logic [2:0] c_ALU_XOR  = 3'd7;

  logic [15:0]   w_imm16;
  logic [25:0]   w_instr_index;
  logic [31:0]   w_in2;
  logic [AW-1:0] w_idx;
  logic [31:0]   mem_q [DEPTH];

  assign w_imm16       = Instr[15:0];
  assign w_instr_index = Instr[25:0];

  // Immediate / jump-target extension selected by extendOp
  always_comb begin
    extendOut = 32'h0;
    case (extendOp)
      c_EXT_ZERO: extendOut = {16'h0, w_imm16};
      c_EXT_SIGN: extendOut = {{16{w_imm16[15]}}, w_imm16};
      c_EXT_LUI:  extendOut = {w_imm16, 16'h0};
      c_EXT_BR:   extendOut = {{14{w_imm16[15]}}, w_imm16, 2'b00};
      c_EXT_JMP:  extendOut = {PC[31:28], w_instr_index, 2'b00};
      default:    extendOut = 32'h0;
    endcase
  end

  assign w_in2 = ALUin2op ? extendOut : RD2;
  assign zero  = (RD1 == w_in2);

  // ALU function select; arithmetic wraps silently, no traps
  always_comb begin
    out = 32'h0;
    case (ALUop)
      c_ALU_ADD:  out = RD1 + w_in2;
      c_ALU_SUB:  out = RD1 - w_in2;
      c_ALU_OR:   out = RD1 | w_in2;
      c_ALU_AND:  out = RD1 & w_in2;
      c_ALU_EQ:   out = {31'h0, RD1 == w_in2};
      c_ALU_SLT:  out = {31'h0, $signed(RD1) < $signed(w_in2)};
      c_ALU_SLTU: out = {31'h0, RD1 < w_in2};
      c_ALU_XOR:  out = RD1 ^ w_in2;
      default:    out = 32'h0;
    endcase
  end

  // Word index: byte-offset bits are dropped and high address bits wrap
  assign w_idx = out[AW+1:2];
  assign DMRD  = mem_q[w_idx];

  // Data memory: async clear while reset is low, otherwise full-word write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (DMop) begin
      mem_q[w_idx] <= RD2;
    end
  end

`ifdef DM_DISPLAY_EN
  // Write trace, printed at the edge that performs the write
  always @(posedge clk) begin
    if (reset && DMop) begin
      $display("@%h: *%h <= %h", PC, {{(30-AW){1'b0}}, w_idx, 2'b00}, RD2);
    end
  end
`endif

  // Bits intentionally not consumed by this slice
  logic unused_bits;
  assign unused_bits = ^{Instr[31:26], out[31:AW+2], out[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_alu_dm_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_dm_ext
//  Purpose  : Self-checking bench for alu_dm_ext: combinational vector table
//             followed by hand-written memory/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_dm_ext;

  logic        clk;
  logic        reset;
  logic [31:0] PC, Instr, RD1, RD2;
  logic [2:0]  extendOp, ALUop;
  logic        ALUin2op, DMop;
  logic [31:0] extendOut, out, DMRD;
  logic        zero;

  int checks;
  int failures;

  alu_dm_ext #(.DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .RD1(RD1), .RD2(RD2),
    .extendOp(extendOp), .ALUop(ALUop), .ALUin2op(ALUin2op), .DMop(DMop),
    .extendOut(extendOut), .out(out), .DMRD(DMRD), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  ext_op;
    logic [2:0]  alu_op;
    logic        in2_op;
    logic [31:0] exp_ext;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Route an address through the ALU as RD1 + 0 and place data on RD2
  task automatic set_addr(input logic [31:0] addr, input logic [31:0] data);
    PC = 32'h0000_3000; Instr = 32'h0; extendOp = 3'd0;
    ALUin2op = 1'b1; ALUop = 3'd0; RD1 = addr; RD2 = data;
  endtask

  initial begin
    checks = 0; failures = 0;
    //            pc            instr         rd1           rd2         ext  alu in2  exp_ext       exp_out       z
    vecs[0]  = '{32'h0,        32'h0000_1234, 32'h0,        32'h0,        3'd2, 3'd0, 1'b1, 32'h1234_0000, 32'h1234_0000, 1'b0};
    vecs[1]  = '{32'h0,        32'h0000_8765, 32'h1234_0000,32'h0,        3'd0, 3'd2, 1'b1, 32'h0000_8765, 32'h1234_8765, 1'b0};
    vecs[2]  = '{32'h0,        32'h0000_FFFC, 32'h10,       32'h0,        3'd1, 3'd0, 1'b1, 32'hFFFF_FFFC, 32'h0000_000C, 1'b0};
    vecs[3]  = '{32'h0,        32'h0000_FFFF, 32'h5,        32'h5,        3'd3, 3'd4, 1'b0, 32'hFFFF_FFFC, 32'h1,         1'b1};
    vecs[4]  = '{32'h3000_0000,32'h0800_0C01, 32'h7,        32'h3,        3'd4, 3'd1, 1'b0, 32'h3000_3004, 32'h4,         1'b0};
    vecs[5]  = '{32'h0,        32'hFFFF_FFFF, 32'h0,        32'h1,        3'd5, 3'd1, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF,32'h1,        3'd6, 3'd5, 1'b0, 32'h0,         32'h1,         1'b0};
    vecs[7]  = '{32'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFF,32'h1,        3'd7, 3'd6, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{32'h0,        32'h0,         32'hF0F0_F0F0,32'hFF00_FF00,3'd0, 3'd3, 1'b0, 32'h0,         32'hF000_F000, 1'b0};
    vecs[9]  = '{32'h0,        32'h0,         32'hF0F0_F0F0,32'hFF00_FF00,3'd0, 3'd7, 1'b0, 32'h0,         32'h0FF0_0FF0, 1'b0};
    vecs[10] = '{32'h0,        32'h0,         32'hFFFF_FFFF,32'h2,        3'd0, 3'd0, 1'b0, 32'h0,         32'h1,         1'b0};
    vecs[11] = '{32'h0,        32'h0,         32'h5,        32'h6,        3'd0, 3'd4, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{32'h0,        32'h0000_FFFC, 32'hFFFF_FFFC,32'h0,        3'd1, 3'd4, 1'b1, 32'hFFFF_FFFC, 32'h1,         1'b1};
    vecs[13] = '{32'h0,        32'h0,         32'h1,        32'hFFFF_FFFF,3'd0, 3'd6, 1'b0, 32'h0,         32'h1,         1'b0};

    // Reset held for two cycles, then released away from the edge
    reset = 1'b0; DMop = 1'b0;
    set_addr(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    set_addr(32'h0000_0FFC, 32'h0);
    #1 check("reset_read_ffc", DMRD, 32'h0);

    // Combinational vector table
    for (int i = 0; i < 14; i++) begin
      PC = vecs[i].pc; Instr = vecs[i].instr; RD1 = vecs[i].rd1; RD2 = vecs[i].rd2;
      extendOp = vecs[i].ext_op; ALUop = vecs[i].alu_op; ALUin2op = vecs[i].in2_op;
      #1;
      check($sformatf("v%0d_ext", i), extendOut, vecs[i].exp_ext);
      check($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("v%0d_zero", i), {31'h0, zero}, {31'h0, vecs[i].exp_zero});
    end

    // Store then load; same-cycle read shows the old word
    @(negedge clk);
    set_addr(32'h0000_0008, 32'hDEAD_BEEF);
    DMop = 1'b1;
    #1 check("pre_write_old", DMRD, 32'h0);
    @(posedge clk); #1;
    DMop = 1'b0;
    #1 check("load_8", DMRD, 32'hDEAD_BEEF);
    set_addr(32'h0000_1008, 32'h0); #1 check("load_1008_wrap", DMRD, 32'hDEAD_BEEF);
    set_addr(32'h0000_0004, 32'h0); #1 check("load_4", DMRD, 32'h0);
    set_addr(32'h0000_000B, 32'h0); #1 check("load_b_unaligned", DMRD, 32'hDEAD_BEEF);

    // Second word at the top of memory, earlier word untouched
    @(negedge clk);
    set_addr(32'h0000_0FFC, 32'h1234_5678); DMop = 1'b1;
    @(posedge clk); #1; DMop = 1'b0;
    #1 check("load_ffc", DMRD, 32'h1234_5678);
    set_addr(32'h0000_0008, 32'h0); #1 check("keep_8", DMRD, 32'hDEAD_BEEF);

    // Reset asserted mid-cycle clears memory immediately
    @(negedge clk);
    reset = 1'b0;
    #1 check("async_clear_8", DMRD, 32'h0);
    set_addr(32'h0000_0FFC, 32'h0); #1 check("async_clear_ffc", DMRD, 32'h0);

    // Edge with reset low and DMop high performs no write
    set_addr(32'h0000_0008, 32'hA5A5_A5A5); DMop = 1'b1;
    @(posedge clk); #1;
    DMop = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1 check("reset_blocks_write", DMRD, 32'h0);

    // First write after release is accepted at the next edge
    set_addr(32'h0000_0010, 32'h0000_0055); DMop = 1'b1;
    @(posedge clk); #1; DMop = 1'b0;
    #1 check("first_write_after_reset", DMRD, 32'h0000_0055);
    set_addr(32'h0000_0008, 32'h0); #1 check("still_clear_8", DMRD, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_dm_ext.md
# alu_dm_ext

Execute/memory datapath slice of the single-cycle MIPS core. It contains three units:
- an immediate/target extender;
- a 32-bit ALU with a selectable second operand;
- a 1024-word synchronous-write, combinational-read data memory addressed by the ALU result.

It sits between the register file and the write-back/PC-select muxes. Its outputs feed the GRF write-data mux and the next-PC logic.

## Interface
Parameters:
- DEPTH, 1024, data memory depth in 32-bit words; address index is ADDR[11:2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears data memory while low.
- PC  in  32  address of current instruction; used for the jump target and the write trace.
- Instr  in  32  current instruction word; [15:0] imm16, [25:0] instr_index.
- RD1  in  32  rs register value; ALU operand 1.
- RD2  in  32  rt register value; ALU operand 2 source and memory write data.
- extendOp  in  3  extender mode.
- ALUop  in  3  ALU function.
- ALUin2op  in  1  0: in2 = RD2; 1: in2 = extendOut.
- DMop  in  1  memory write enable.
- extendOut  out  32  extender result.
- out  out  32  ALU result; also the memory address.
- DMRD  out  32  memory read data.
- zero  out  1  1 when RD1 == in2.

## Operation
Extender (combinational), by extendOp:
- 0: zero-extend imm16.
- 1: sign-extend imm16.
- 2: {imm16, 16'b0} (lui).
- 3: sign-extend imm16 << 2 (branch offset).
- 4: {PC[31:28], instr_index, 2'b00} (jump target).
- 5–7: 0.

ALU (combinational, 32-bit, no overflow traps), by ALUop:
- 0: in1 + in2, wraps mod 2^32.
- 1: in1 − in2, wraps mod 2^32.
- 2: in1 | in2.
- 3: in1 & in2.
- 4: equality compare; out = {31'b0, in1 == in2}, and out[0] is the branch-taken bit.
- 5: signed set-less-than, 1 or 0.
- 6: unsigned set-less-than.
- 7: in1 ^ in2.

Data memory:
- Index = out[11:2]. out[1:0] and out[31:12] are ignored: no alignment check, and high addresses wrap.
- Read: DMRD = mem[index], combinational.
- Write: on rising clk when DMop=1 and reset=1, mem[index] <= RD2 (full word).
- Reset: while reset=0, all words are forced to 0 asynchronously. Reset overrides a concurrent write.

## Timing
- Extender, ALU, zero and DMRD are purely combinational, with zero cycle latency from their inputs.
- A write at edge N is visible on DMRD immediately after edge N.
- Same-cycle read of the address being written returns the old value until the edge.
- Reset values:
  - All memory words are 0, so DMRD = 0 for any address.
  - Combinational outputs follow their inputs during reset.
- Deasserting reset takes effect on the next rising edge; the first write is accepted at that edge if DMop=1.
- Reset asserted mid-cycle clears memory at once; an edge coinciding with reset=0 performs no write.

## Configuration
- DM_DISPLAY_EN defined: each accepted write prints "@%h: *%h <= %h" with PC, the 32-bit address {20'b0, index, 2'b00}, and the written data.
  - Printing occurs at the writing clock edge.
- DM_DISPLAY_EN undefined: no display statements are compiled. Functional behaviour is identical.

## Test plan
- Reset then read: reset=0 for 2 cycles, then release; any address (e.g. out=0x0000_0FFC) -> DMRD=0.
- lui/ori chain:
  - Instr imm=0x1234, extendOp=2 -> extendOut=0x1234_0000.
  - RD1=0x1234_0000, imm=0x8765, extendOp=0, ALUin2op=1, ALUop=2 -> out=0x1234_8765.
- Sign extension and add: imm=0xFFFC, extendOp=1, RD1=0x10, ALUop=0 -> out=0x0000_000C.
- Store/load:
  - DMop=1, out=0x8, RD2=0xDEAD_BEEF at edge -> DMRD=0xDEAD_BEEF afterwards.
  - out=0x1008 reads the same word (wrap); out=0x4 still reads 0.
- Branch/jump targets:
  - RD1=RD2=5, ALUop=4 -> out=1, zero=1.
  - imm=0xFFFF, extendOp=3 -> 0xFFFF_FFFC.
  - PC=0x3000_0000, instr_index=0x0000_C01, extendOp=4 -> 0x3000_3004.
- Reset during write: assert reset=0 coincident with DMop=1 edge at out=0x8 -> word stays 0; earlier stored data cleared.
